seg7_status_pager: RTL and testbench

- Parametrised multi-channel status display engine for DE2-115 debug builds.
- Takes NUM_CH packed binary status values (FSM state codes, I2C state, ACK counts, …) and shows one channel at a time, in decimal, on DIGITS active-low seven-segment displays.
- Converts with a sequential double-dabble engine; a debounced key pulse pages through the channels.
- Sits beside the top-level wrapper, between debounce and the HEX pins.

---
 rtl/seg7_status_pager.sv | 188 ++++++++++++++++++
 tb/tb_seg7_status_pager.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_status_pager.sv
// seg7_status_pager
//   Multi-channel status display engine. Shows one of NUM_CH packed binary
//   status values at a time, in decimal, on DIGITS active-low seven-segment
//   displays. A sequential double-dabble engine (LOAD, VAL_W x SHIFT, DONE)
//   refreshes the display continuously. A debounced key pulse on i_next
//   pages to the next channel and restarts the conversion.
//
// Ports
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_val    NUM_CH*VAL_W packed values, channel k at [k*VAL_W +: VAL_W]
//   i_next   one-cycle page-advance pulse
//   o_seven  DIGITS*7 segments, digit d at [d*7 +: 7], gfedcba active-low
//   o_page   displayed channel index
//   o_valid  high once the first conversion has completed since reset
//
// Configuration macro
//   SEG7_PAGER_BLANK_EN  leading-zero blanking (digit 0 always shows a numeral)
module seg7_status_pager #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned VAL_W  = 8,
    parameter int unsigned DIGITS = 4
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic [NUM_CH*VAL_W-1:0]                        i_val,
    input  logic                                           i_next,
    output logic [DIGITS*7-1:0]                            o_seven,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_page,
    output logic                                           o_valid
);

    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam int unsigned PAGE_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W    = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam logic [31:0] MAX_DISP = pow10(DIGITS) - 32'd1;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;

    logic [VAL_W-1:0]    ch_sel;
    logic [BCD_W-1:0]    bcd_adj;
    logic [DIGITS*7-1:0] seg_next;
    logic [PAGE_W-1:0]   page_inc;

    // Channel mux on the currently displayed page.
    always_comb begin
        ch_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (o_page == PAGE_W'(k)) begin
                ch_sel = i_val[k*VAL_W +: VAL_W];
            end
        end
    end

    always_comb begin
        if (o_page == PAGE_W'(NUM_CH - 1)) begin
            page_inc = '0;
        end else begin
            page_inc = o_page + 1'b1;
        end
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Segment codes for the finished BCD word, scanned from the top digit
    // down so that leading zeros can be recognised when blanking is built in.
`ifdef SEG7_PAGER_BLANK_EN
    logic lead;
`endif
    always_comb begin
        seg_next = '1;
`ifdef SEG7_PAGER_BLANK_EN
        lead = 1'b1;
`endif
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ovf) begin
                seg_next[(DIGITS-1-i)*7 +: 7] = SEG_DASH;
            end else begin
`ifdef SEG7_PAGER_BLANK_EN
                if (bcd[(DIGITS-1-i)*4 +: 4] != 4'd0) begin
                    lead = 1'b0;
                end
                if (lead && (i != DIGITS - 1)) begin
                    seg_next[(DIGITS-1-i)*7 +: 7] = SEG_BLANK;
                end else begin
                    seg_next[(DIGITS-1-i)*7 +: 7] = seg_of(bcd[(DIGITS-1-i)*4 +: 4]);
                end
`else
                seg_next[(DIGITS-1-i)*7 +: 7] = seg_of(bcd[(DIGITS-1-i)*4 +: 4]);
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= LOAD;
            shreg   <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            o_seven <= '1;
            o_page  <= '0;
            o_valid <= 1'b0;
        end else if (i_next) begin
            // A page request aborts whatever is in flight (including a DONE
            // in this very cycle) so the display only ever jumps straight
            // from the old channel to the new one.
            o_page <= page_inc;
            state  <= LOAD;
        end else begin
            case (state)
                LOAD: begin
                    shreg <= ch_sel;
                    bcd   <= '0;
                    ovf   <= (32'(ch_sel) > MAX_DISP);
                    cnt   <= CNT_W'(VAL_W - 1);
                    state <= SHIFT;
                end
                SHIFT: begin
                    // BCD bits carried out of the top are dropped; ovf
                    // already flags every value that would need them.
                    bcd   <= {bcd_adj[BCD_W-2:0], shreg[VAL_W-1]};
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    o_seven <= seg_next;
                    o_valid <= 1'b1;
                    state   <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_status_pager.sv
// tb_seg7_status_pager
//   Bench for seg7_status_pager. Two instances: A (4 ch, 8-bit, 4 digits)
//   and B (1 ch, 16-bit, 4 digits, exercises overflow and single-channel
//   paging). A timing-level model tracks, for each instance, the position in
//   the conversion period, the captured value and the expected display; a
//   compare process checks every cycle, and directed steps pin the model
//   with literal segment codes.
module tb_seg7_status_pager;

    localparam int VW_A = 8;
    localparam int VW_B = 16;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SEGS [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
`ifdef SEG7_PAGER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0] LZ = BLANK ? SB : S0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        next_a, next_b;
    logic [7:0]  ch_a [4];
    logic [15:0] ch_b;
    logic [31:0] val_a;
    logic [27:0] seven_a, seven_b;
    logic [1:0]  page_a;
    logic [0:0]  page_b;
    logic        valid_a, valid_b;

    int checks   = 0;
    int failures = 0;

    assign val_a = {ch_a[3], ch_a[2], ch_a[1], ch_a[0]};

    always #5 clk = ~clk;

    seg7_status_pager #(.NUM_CH(4), .VAL_W(VW_A), .DIGITS(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(val_a), .i_next(next_a),
        .o_seven(seven_a), .o_page(page_a), .o_valid(valid_a)
    );

    seg7_status_pager #(.NUM_CH(1), .VAL_W(VW_B), .DIGITS(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(ch_b), .i_next(next_b),
        .o_seven(seven_b), .o_page(page_b), .o_valid(valid_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Decimal rendering of a value on four digits, straight from the rules.
    function automatic logic [27:0] exp_disp(input int unsigned v);
        logic [27:0] r;
        int unsigned p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999)                    r[i*7 +: 7] = SD;
            else if (BLANK && i > 0 && v < p) r[i*7 +: 7] = SB;
            else                              r[i*7 +: 7] = SEGS[int'((v / p) % 10)];
            p = p * 10;
        end
        return r;
    endfunction

    // Model: phase 0 is the capture cycle, 1..VW the shift cycles, VW+1 the
    // cycle whose closing edge publishes the result.
    int unsigned ph_a, ph_b, lat_a, lat_b, pg_a;
    logic [27:0] m_disp_a, m_disp_b;
    logic        m_valid_a, m_valid_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_a = 0; lat_a = 0; pg_a = 0; m_disp_a = '1; m_valid_a = 1'b0;
            ph_b = 0; lat_b = 0;           m_disp_b = '1; m_valid_b = 1'b0;
        end else begin
            if (next_a) begin
                pg_a = (pg_a + 1) % 4;
                ph_a = 0;
            end else if (ph_a == 0) begin
                lat_a = ch_a[pg_a];
                ph_a  = 1;
            end else if (ph_a == VW_A + 1) begin
                m_disp_a = exp_disp(lat_a); m_valid_a = 1'b1; ph_a = 0;
            end else begin
                ph_a++;
            end
            if (next_b) begin
                ph_b = 0;
            end else if (ph_b == 0) begin
                lat_b = ch_b;
                ph_b  = 1;
            end else if (ph_b == VW_B + 1) begin
                m_disp_b = exp_disp(lat_b); m_valid_b = 1'b1; ph_b = 0;
            end else begin
                ph_b++;
            end
        end
    end

    always @(negedge clk) begin
        chk("a_seven", 32'(seven_a), 32'(m_disp_a));
        chk("a_page",  32'(page_a),  32'(pg_a));
        chk("a_valid", 32'(valid_a), 32'(m_valid_a));
        chk("b_seven", 32'(seven_b), 32'(m_disp_b));
        chk("b_page",  32'(page_b),  32'd0);
        chk("b_valid", 32'(valid_b), 32'(m_valid_b));
    end

    task automatic pulse_a();
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase_a(input int unsigned p);
        int n;
        n = 0;
        while (ph_a != p && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase_a", 32'(ph_a == p), 32'd1);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  bad;
        rst_n = 1'b0; next_a = 1'b0; next_b = 1'b0;
        ch_a[0] = 8'd123; ch_a[1] = 8'd7; ch_a[2] = 8'd0; ch_a[3] = 8'd255;
        ch_b = 16'd12345;

        // Reset state.
        cycles(3);
        chk("rst_seven_a", 32'(seven_a), 32'h0FFF_FFFF);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_seven_b", 32'(seven_b), 32'h0FFF_FFFF);
        rst_n = 1'b1;

        // First conversion lands exactly VAL_W+2 edges after release.
        cycles(9);
        chk("first_valid_early", 32'(valid_a), 32'd0);
        cycles(1);
        chk("first_123", 32'(seven_a), 32'({LZ, S1, S2, S3}));
        chk("first_valid", 32'(valid_a), 32'd1);

        // Overflow on the 16-bit instance, then a value that fits.
        cycles(10);
        chk("ovf_dash", 32'(seven_b), 32'({SD, SD, SD, SD}));
        ch_b = 16'd9999;
        n = 0;
        while (seven_b !== {S9, S9, S9, S9} && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_9999", 32'(seven_b), 32'({S9, S9, S9, S9}));
        next_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0;
        chk("single_ch_page", 32'(page_b), 32'd0);

        // Page wrap.
        pulse_a();
        chk("page1", 32'(page_a), 32'd1);
        cycles(VW_A + 3);
        chk("ch1_0007", 32'(seven_a), 32'({LZ, LZ, LZ, S7}));
        pulse_a();
        pulse_a();
        chk("page3", 32'(page_a), 32'd3);
        cycles(VW_A + 3);
        chk("ch3_0255", 32'(seven_a), 32'({LZ, S2, S5, S5}));
        pulse_a();
        chk("page_wrap0", 32'(page_a), 32'd0);
        cycles(VW_A + 3);
        chk("ch0_again", 32'(seven_a), 32'({LZ, S1, S2, S3}));

        // Zero and a single-digit value on channel 2.
        pulse_a();
        pulse_a();
        cycles(VW_A + 3);
        chk("ch2_zero", 32'(seven_a), 32'({LZ, LZ, LZ, S0}));
        ch_a[2] = 8'd5;
        cycles(2 * (VW_A + 2) + 1);
        chk("ch2_five", 32'(seven_a), 32'({LZ, LZ, LZ, S5}));

        // Abort at the 5th shift cycle: 0012 must go straight to 0034.
        pulse_a();
        pulse_a();
        ch_a[0] = 8'd12; ch_a[1] = 8'd34;
        cycles(2 * (VW_A + 2) + 1);
        chk("abort_pre", 32'(seven_a), 32'({LZ, LZ, S1, S2}));
        wait_phase_a(5);
        next_a = 1'b1;
        seen = 1'b0; bad = 1'b0; n = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            next_a = 1'b0;
            n++;
            if (seven_a === {LZ, LZ, S3, S4}) seen = 1'b1;
            else if (seven_a !== {LZ, LZ, S1, S2}) bad = 1'b1;
        end
        chk("abort_no_torn", 32'(bad), 32'd0);
        chk("abort_new_0034", 32'(seen), 32'd1);
        chk("abort_latency_ok", 32'(n <= VW_A + 3), 32'd1);
        chk("abort_page", 32'(page_a), 32'd1);

        // Asynchronous reset in the middle of a shift.
        wait_phase_a(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_seven", 32'(seven_a), 32'h0FFF_FFFF);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_page", 32'(page_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(VW_A + 1);
        chk("arst_valid_early", 32'(valid_a), 32'd0);
        cycles(1);
        chk("arst_first", 32'(seven_a), 32'({LZ, LZ, S1, S2}));
        chk("arst_valid_set", 32'(valid_a), 32'd1);

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
